perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank_if.sv | 36 +++
 rtl/perf_counter_bank.sv | 93 +++++++++
 tb/tb_perf_counter_bank.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: count controls, read port and overflow flags.
// PERF_COUNTER_SNAPSHOT_EN adds the snapshot strobe.
interface perf_counter_bank_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 64
);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              enable;
   logic [NUM_CH-1:0] increment;
   logic [NUM_CH-1:0] clear;
   logic              rd_en;
   logic [SEL_W-1:0]  rd_sel;
   logic              rd_valid;
   logic [WIDTH-1:0]  rd_data;
   logic [NUM_CH-1:0] overflow;
`ifdef PERF_COUNTER_SNAPSHOT_EN
   logic              snapshot;
`endif

   modport master (
      output enable, increment, clear, rd_en, rd_sel,
`ifdef PERF_COUNTER_SNAPSHOT_EN
      output snapshot,
`endif
      input  rd_valid, rd_data, overflow
   );

   modport slave (
      input  enable, increment, clear, rd_en, rd_sel,
`ifdef PERF_COUNTER_SNAPSHOT_EN
      input  snapshot,
`endif
      output rd_valid, rd_data, overflow
   );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with sticky overflow flags and a 1-cycle read port.
// Define PERF_COUNTER_SNAPSHOT_EN to add atomic shadow copies that reads return instead of live counts.
module perf_counter_bank #(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 64,
   parameter int SATURATE = 0
) (
   input logic                  clk,
   input logic                  rst,
   perf_counter_bank_if.slave   bus
);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] read_src [NUM_CH];
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;
   logic             sel_in_range;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] count_reg;
         logic [WIDTH-1:0] count_next;
         logic             overflow_reg;
         logic             overflow_next;

         // Clear wins over increment; the overflow flag is sticky until clear.
         always_comb begin
            count_next    = count_reg;
            overflow_next = overflow_reg;
            if (bus.clear[gi]) begin
               count_next    = '0;
               overflow_next = 1'b0;
            end else if (bus.enable && bus.increment[gi]) begin
               if (count_reg == ALL_ONES) begin
                  overflow_next = 1'b1;
                  count_next    = (SATURATE != 0) ? ALL_ONES : '0;
               end else begin
                  count_next = count_reg + ONE;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               count_reg    <= '0;
               overflow_reg <= 1'b0;
            end else begin
               count_reg    <= count_next;
               overflow_reg <= overflow_next;
            end
         end

         assign bus.overflow[gi] = overflow_reg;

`ifdef PERF_COUNTER_SNAPSHOT_EN
         logic [WIDTH-1:0] shadow_reg;

         // Captures the pre-update count, so all channels are sampled at the same instant.
         always_ff @(posedge clk) begin
            if (rst) begin
               shadow_reg <= '0;
            end else if (bus.snapshot) begin
               shadow_reg <= count_reg;
            end
         end

         assign read_src[gi] = shadow_reg;
`else
         assign read_src[gi] = count_reg;
`endif
      end
   endgenerate

   assign sel_in_range = ({{(32-SEL_W){1'b0}}, bus.rd_sel} < 32'(NUM_CH));

   // rd_data only moves on a read, so it holds the last result while rd_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_reg <= sel_in_range ? read_src[bus.rd_sel] : '0;
         end
      end
   end

   assign bus.rd_valid = rd_valid_reg;
   assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a wrapping and a saturating instance share stimulus;
// a scoreboard queue holds expected read results popped by an independent monitor.
module tb_perf_counter_bank;
   localparam int NUM_CH = 3;
   localparam int WIDTH  = 8;

   typedef struct {
      logic [7:0] w;
      logic [7:0] s;
      logic [1:0] sel;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   exp_t q[$];
   exp_t e;

   perf_counter_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus_w ();
   perf_counter_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus_s ();

   assign bus_s.enable    = bus_w.enable;
   assign bus_s.increment = bus_w.increment;
   assign bus_s.clear     = bus_w.clear;
   assign bus_s.rd_en     = bus_w.rd_en;
   assign bus_s.rd_sel    = bus_w.rd_sel;
`ifdef PERF_COUNTER_SNAPSHOT_EN
   assign bus_s.snapshot  = bus_w.snapshot;
`endif

   perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(0)) dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bus_w)
   );

   perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic read_ch(input logic [1:0] sel, input logic [7:0] ew, input logic [7:0] es,
                          input bit snap);
`ifdef PERF_COUNTER_SNAPSHOT_EN
      if (snap) begin
         bus_w.snapshot = 1'b1;
         @(negedge clk);
         bus_w.snapshot = 1'b0;
      end
`endif
      bus_w.rd_en  = 1'b1;
      bus_w.rd_sel = sel;
      q.push_back('{w: ew, s: es, sel: sel});
      @(negedge clk);
      bus_w.rd_en = 1'b0;
   endtask

   // Monitor: every rd_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus_w.rd_valid === 1'b1 || bus_s.rd_valid === 1'b1) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rd_valid: got wrap=%0b sat=%0b, required none pending",
                     bus_w.rd_valid, bus_s.rd_valid);
         end else begin
            e = q.pop_front();
            if (bus_w.rd_valid !== 1'b1 || bus_s.rd_valid !== 1'b1 ||
                bus_w.rd_data !== e.w || bus_s.rd_data !== e.s) begin
               miscompares++;
               $display("FAIL read_sel%0d: got valid=%0b/%0b data=%0d/%0d, required valid=1/1 data=%0d/%0d",
                        e.sel, bus_w.rd_valid, bus_s.rd_valid, bus_w.rd_data, bus_s.rd_data, e.w, e.s);
            end else begin
               $display("read sel=%0d wrap=%0d sat=%0d ok", e.sel, bus_w.rd_data, bus_s.rd_data);
            end
         end
      end
   end

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst              = 1'b1;
      bus_w.enable     = 1'b0;
      bus_w.increment  = '0;
      bus_w.clear      = '0;
      bus_w.rd_en      = 1'b1;
      bus_w.rd_sel     = '0;
`ifdef PERF_COUNTER_SNAPSHOT_EN
      bus_w.snapshot   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_rd_valid_wrap", 64'(bus_w.rd_valid), 64'd0);
      check("reset_rd_valid_sat", 64'(bus_s.rd_valid), 64'd0);
      check("reset_rd_data_wrap", 64'(bus_w.rd_data), 64'd0);
      check("reset_overflow_wrap", 64'(bus_w.overflow), 64'd0);
      check("reset_overflow_sat", 64'(bus_s.overflow), 64'd0);
      rst         = 1'b0;
      bus_w.rd_en = 1'b0;

      // Ten counts on ch0
      bus_w.enable    = 1'b1;
      bus_w.increment = 3'b001;
      repeat (10) @(negedge clk);
      bus_w.increment = 3'b000;
      read_ch(2'd0, 8'd10, 8'd10, 1'b1);
      check("ch0_overflow_clear", 64'(bus_w.overflow), 64'd0);

      // Ch1 to the top, then over it
      bus_w.increment = 3'b010;
      repeat (255) @(negedge clk);
      bus_w.increment = 3'b000;
      read_ch(2'd1, 8'd255, 8'd255, 1'b1);
      check("ch1_no_overflow_at_max", 64'(bus_w.overflow), 64'd0);
      bus_w.increment = 3'b010;
      @(negedge clk);
      bus_w.increment = 3'b000;
      check("ch1_overflow_wrap", 64'(bus_w.overflow), 64'b010);
      check("ch1_overflow_sat", 64'(bus_s.overflow), 64'b010);
      read_ch(2'd1, 8'd0, 8'd255, 1'b1);
      bus_w.increment = 3'b010;
      @(negedge clk);
      bus_w.increment = 3'b000;
      check("ch1_overflow_sticky_wrap", 64'(bus_w.overflow), 64'b010);
      check("ch1_overflow_sticky_sat", 64'(bus_s.overflow), 64'b010);
      read_ch(2'd1, 8'd1, 8'd255, 1'b1);

      // Ch2: clear beats increment, same-cycle read sees the old value
      bus_w.increment = 3'b100;
      repeat (5) @(negedge clk);
      bus_w.increment = 3'b000;
`ifdef PERF_COUNTER_SNAPSHOT_EN
      bus_w.snapshot = 1'b1;
      @(negedge clk);
      bus_w.snapshot = 1'b0;
`endif
      bus_w.clear     = 3'b100;
      bus_w.increment = 3'b100;
      bus_w.rd_en     = 1'b1;
      bus_w.rd_sel    = 2'd2;
      q.push_back('{w: 8'd5, s: 8'd5, sel: 2'd2});
      @(negedge clk);
      bus_w.clear     = 3'b000;
      bus_w.increment = 3'b000;
      bus_w.rd_en     = 1'b0;
      check("ch2_overflow_after_clear", 64'(bus_w.overflow), 64'b010);
      read_ch(2'd2, 8'd0, 8'd0, 1'b1);

      // Clearing ch1 drops its sticky flag
      bus_w.clear = 3'b010;
      @(negedge clk);
      bus_w.clear = 3'b000;
      check("ch1_clear_overflow_wrap", 64'(bus_w.overflow), 64'd0);
      check("ch1_clear_overflow_sat", 64'(bus_s.overflow), 64'd0);
      read_ch(2'd1, 8'd0, 8'd0, 1'b1);
      bus_w.increment = 3'b100;
      repeat (3) @(negedge clk);
      bus_w.increment = 3'b000;

      // Disabled: all strobes ignored
      bus_w.enable    = 1'b0;
      bus_w.increment = 3'b111;
      repeat (20) @(negedge clk);
      bus_w.increment = 3'b000;
      read_ch(2'd3, 8'd0, 8'd0, 1'b1);
      read_ch(2'd2, 8'd3, 8'd3, 1'b0);
      read_ch(2'd1, 8'd0, 8'd0, 1'b0);
      read_ch(2'd0, 8'd10, 8'd10, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_rd_valid", 64'(bus_w.rd_valid), 64'd0);
      check("idle_rd_data_hold", 64'(bus_w.rd_data), 64'd10);

      // Reset mid-count with a read pending
      bus_w.enable    = 1'b1;
      bus_w.increment = 3'b001;
      repeat (4) @(negedge clk);
      rst          = 1'b1;
      bus_w.rd_en  = 1'b1;
      bus_w.rd_sel = 2'd0;
      @(negedge clk);
      check("rst_rd_valid_wrap", 64'(bus_w.rd_valid), 64'd0);
      check("rst_rd_valid_sat", 64'(bus_s.rd_valid), 64'd0);
      check("rst_rd_data", 64'(bus_w.rd_data), 64'd0);
      rst             = 1'b0;
      bus_w.rd_en     = 1'b0;
      bus_w.increment = 3'b000;
      check("rst_overflow", 64'(bus_s.overflow), 64'd0);
      read_ch(2'd0, 8'd0, 8'd0, 1'b1);

`ifdef PERF_COUNTER_SNAPSHOT_EN
      // Shadow holds the value captured at the snapshot edge
      bus_w.increment = 3'b001;
      repeat (7) @(negedge clk);
      bus_w.increment = 3'b000;
      bus_w.snapshot  = 1'b1;
      @(negedge clk);
      bus_w.snapshot  = 1'b0;
      bus_w.increment = 3'b001;
      repeat (3) @(negedge clk);
      bus_w.increment = 3'b000;
      read_ch(2'd0, 8'd7, 8'd7, 1'b0);
      bus_w.snapshot = 1'b1;
      bus_w.rd_en    = 1'b1;
      bus_w.rd_sel   = 2'd0;
      q.push_back('{w: 8'd7, s: 8'd7, sel: 2'd0});
      @(negedge clk);
      bus_w.snapshot = 1'b0;
      bus_w.rd_en    = 1'b0;
      read_ch(2'd0, 8'd10, 8'd10, 1'b0);
`endif

      repeat (4) @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_reads: got %0d outstanding, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
